// File: rtl/frog_referee_pkg.sv
// Shared types and constants for the frog game-rules referee.
package frog_referee_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned BOX_W   = 4 * COORD_W;
  localparam int unsigned LIVES_W = 4;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned HOLD_W  = 8;

  // Field offsets of one packed {x1,x2,y1,y2} box
  localparam int unsigned X1_OFF = 3 * COORD_W;
  localparam int unsigned X2_OFF = 2 * COORD_W;
  localparam int unsigned Y1_OFF = 1 * COORD_W;
  localparam int unsigned Y2_OFF = 0;

  localparam int unsigned DEF_GOAL_Y      = 24;
  localparam int unsigned DEF_HOLD_FRAMES = 30;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_HOLD_DIE  = 2'd1,
    ST_HOLD_GOAL = 2'd2,
    ST_OVER      = 2'd3
  } state_e;

  // Bounding box, x1 in the most significant field
  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] y2;
  } box_t;

endpackage

// File: rtl/frog_referee_box_overlap.sv
// Strict overlap of two boxes; touching edges do not count.
module box_overlap
  import frog_referee_pkg::*;
(
  input  box_t i_a,
  input  box_t i_b,
  output logic o_overlap_c
);

  assign o_overlap_c = (i_a.x1 < i_b.x2) && (i_a.x2 > i_b.x1) &&
                       (i_a.y1 < i_b.y2) && (i_a.y2 > i_b.y1);

endmodule

// File: rtl/frog_referee.sv
// Game referee: collision/goal detection, lives, score and frog hold control.
module frog_referee
  import frog_referee_pkg::*;
#(
  parameter int unsigned N_OBS       = 4,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned GOAL_Y      = DEF_GOAL_Y,
  parameter int unsigned HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ani_stb,
  input  logic                     i_animate,
  input  logic [COORD_W-1:0]       i_frog_x1,
  input  logic [COORD_W-1:0]       i_frog_x2,
  input  logic [COORD_W-1:0]       i_frog_y1,
  input  logic [COORD_W-1:0]       i_frog_y2,
  input  logic [BOX_W*N_OBS-1:0]   i_obs_box,
  output logic                     o_dead,
  output logic                     o_hit,
  output logic                     o_goal,
  output logic [LIVES_W-1:0]       o_lives,
  output logic [SCORE_W-1:0]       o_score,
  output logic [1:0]               o_state
);

  box_t             frog_box;
  logic [N_OBS-1:0] ov_c;

  logic [N_OBS-1:0]   ov_q,     ov_d;
  logic               goal_r_q, goal_r_d;
  state_e             state_q,  state_d;
  logic [HOLD_W-1:0]  cnt_q,    cnt_d;
  logic               dead_q,   dead_d;
  logic               hit_q,    hit_d;
  logic               goal_q,   goal_d;
  logic [LIVES_W-1:0] lives_q,  lives_d;
  logic [SCORE_W-1:0] score_q,  score_d;

  logic hit_r;
  logic adv;

  assign frog_box = '{x1: i_frog_x1, x2: i_frog_x2, y1: i_frog_y1, y2: i_frog_y2};

  // One overlap checker per obstacle
  for (genvar k = 0; k < int'(N_OBS); k++) begin : g_obs
    box_overlap u_box_overlap (
      .i_a         (frog_box),
      .i_b         (box_t'(i_obs_box[BOX_W*k +: BOX_W])),
      .o_overlap_c (ov_c[k])
    );
  end

  assign hit_r = |ov_q;
  assign adv   = i_ani_stb && i_animate;

  // State and pipeline registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ov_q     <= '0;
      goal_r_q <= 1'b0;
      state_q  <= ST_PLAY;
      cnt_q    <= '0;
      dead_q   <= 1'b0;
      hit_q    <= 1'b0;
      goal_q   <= 1'b0;
      lives_q  <= LIVES_W'(LIVES);
      score_q  <= '0;
    end else begin
      ov_q     <= ov_d;
      goal_r_q <= goal_r_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dead_q   <= dead_d;
      hit_q    <= hit_d;
      goal_q   <= goal_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
    end
  end

  // Next-state: rules advance only on an enabled animation strobe
  always_comb begin
    ov_d     = ov_c;
    goal_r_d = (i_frog_y1 <= COORD_W'(GOAL_Y));
    state_d  = state_q;
    cnt_d    = cnt_q;
    dead_d   = dead_q;
    hit_d    = 1'b0;
    goal_d   = 1'b0;
    lives_d  = lives_q;
    score_d  = score_q;

    if (adv) begin
      unique case (state_q)
        ST_PLAY: begin
          if (hit_r) begin
            lives_d = (lives_q != '0) ? lives_q - LIVES_W'(1) : lives_q;
            hit_d   = 1'b1;
            cnt_d   = HOLD_W'(HOLD_FRAMES);
            dead_d  = 1'b1;
            state_d = ST_HOLD_DIE;
          end else if (goal_r_q) begin
            score_d = (score_q != '1) ? score_q + SCORE_W'(1) : score_q;
            goal_d  = 1'b1;
            cnt_d   = HOLD_W'(HOLD_FRAMES);
            dead_d  = 1'b1;
            state_d = ST_HOLD_GOAL;
          end
        end
        ST_HOLD_DIE, ST_HOLD_GOAL: begin
          if (cnt_q == HOLD_W'(1)) begin
            cnt_d  = '0;
            dead_d = 1'b0;
            if (state_q == ST_HOLD_DIE && lives_q == '0) begin
              dead_d  = 1'b1;
              state_d = ST_OVER;
            end else begin
              state_d = ST_PLAY;
            end
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
        ST_OVER: begin
          dead_d = 1'b1;
        end
        default: begin
          state_d = ST_PLAY;
        end
      endcase
    end
  end

  assign o_dead  = dead_q;
  assign o_hit   = hit_q;
  assign o_goal  = goal_q;
  assign o_lives = lives_q;
  assign o_score = score_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_frog_referee.sv
// Directed bench for frog_referee with a rule-level reference model.
module tb_frog_referee;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_ani_stb;
  logic         i_animate;
  logic [11:0]  i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2;
  logic [191:0] i_obs_box;
  logic         o_dead, o_hit, o_goal;
  logic [3:0]   o_lives;
  logic [7:0]   o_score;
  logic [1:0]   o_state;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  frog_referee dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_ani_stb (i_ani_stb),
    .i_animate (i_animate),
    .i_frog_x1 (i_frog_x1),
    .i_frog_x2 (i_frog_x2),
    .i_frog_y1 (i_frog_y1),
    .i_frog_y2 (i_frog_y2),
    .i_obs_box (i_obs_box),
    .o_dead    (o_dead),
    .o_hit     (o_hit),
    .o_goal    (o_goal),
    .o_lives   (o_lives),
    .o_score   (o_score),
    .o_state   (o_state)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: game phase, lives, score and frames left to hold
  int m_phase, m_lives, m_score, m_left;
  bit m_dead, m_hit, m_goal;
  bit seen_hit, seen_goal;  // what the referee saw one clock ago

  function automatic bit frog_touches_any();
    bit any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int ox1 = int'(i_obs_box[48*k+36 +: 12]);
      int ox2 = int'(i_obs_box[48*k+24 +: 12]);
      int oy1 = int'(i_obs_box[48*k+12 +: 12]);
      int oy2 = int'(i_obs_box[48*k    +: 12]);
      if (int'(i_frog_x1) < ox2 && int'(i_frog_x2) > ox1 &&
          int'(i_frog_y1) < oy2 && int'(i_frog_y2) > oy1)
        any = 1'b1;
    end
    return any;
  endfunction

  always @(posedge i_clk) begin
    if (i_rst) begin
      m_phase = 0; m_lives = 3; m_score = 0; m_left = 0;
      m_dead = 0; m_hit = 0; m_goal = 0;
      seen_hit = 0; seen_goal = 0;
    end else begin
      m_hit = 0; m_goal = 0;
      if (i_ani_stb && i_animate) begin
        if (m_phase == 0 && seen_hit) begin
          if (m_lives > 0) m_lives = m_lives - 1;
          m_hit = 1; m_dead = 1; m_left = 30; m_phase = 1;
        end else if (m_phase == 0 && seen_goal) begin
          m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
          m_goal = 1; m_dead = 1; m_left = 30; m_phase = 2;
        end else if (m_phase == 1 || m_phase == 2) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (m_phase == 1 && m_lives == 0) m_phase = 3;
            else begin m_phase = 0; m_dead = 0; end
          end
        end
      end
      seen_hit  = frog_touches_any();
      seen_goal = (int'(i_frog_y1) <= 24);
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge i_clk) begin
    if (chk_en) begin
      cmp("state", int'(o_state), m_phase);
      cmp("dead",  int'(o_dead),  int'(m_dead));
      cmp("hit",   int'(o_hit),   int'(m_hit));
      cmp("goal",  int'(o_goal),  int'(m_goal));
      cmp("lives", int'(o_lives), m_lives);
      cmp("score", int'(o_score), m_score);
    end
  end

  task automatic set_obs(input int k, input int x1, input int x2, input int y1, input int y2);
    i_obs_box[48*k +: 48] = {12'(x1), 12'(x2), 12'(y1), 12'(y2)};
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 4; k++) set_obs(k, 1000, 1010, 1000, 1010);
  endtask

  task automatic set_frog(input int x1, input int x2, input int y1, input int y2);
    i_frog_x1 = 12'(x1); i_frog_x2 = 12'(x2);
    i_frog_y1 = 12'(y1); i_frog_y2 = 12'(y2);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic strobe();
    @(negedge i_clk) i_ani_stb = 1'b1;
    @(negedge i_clk) i_ani_stb = 1'b0;
  endtask

  // Strobe until the referee reports phase s; overrunning the budget is a failure
  task automatic strobe_until(input string name, input int s, input int budget);
    int n = 0;
    while (int'(o_state) != s && n < budget) begin
      strobe();
      n++;
    end
    cmp(name, int'(o_state), s);
  endtask

  initial begin
    int n;
    bit dead_seen;
    i_rst = 1'b1; i_ani_stb = 1'b0; i_animate = 1'b1;
    i_obs_box = '0;
    clear_obs();
    set_frog(309, 331, 449, 471);
    idle(3);
    i_rst = 1'b0;
    chk_en = 1'b1;
    idle(1);
    cmp("rst_state", int'(o_state), 0);
    cmp("rst_lives", int'(o_lives), 3);
    cmp("rst_score", int'(o_score), 0);
    cmp("rst_dead",  int'(o_dead),  0);

    // Nothing nearby: 100 quiet frames
    dead_seen = 0;
    for (int i = 0; i < 100; i++) begin
      strobe();
      if (o_dead) dead_seen = 1;
    end
    cmp("idle_dead_seen", int'(dead_seen), 0);
    cmp("idle_state", int'(o_state), 0);

    // Overlapping obstacle 2: hit, then exactly 30 held frames
    set_obs(2, 320, 360, 440, 480);
    idle(1);
    strobe();
    cmp("hit1_pulse", int'(o_hit), 1);
    cmp("hit1_lives", int'(o_lives), 2);
    cmp("hit1_state", int'(o_state), 1);
    idle(1);
    cmp("hit1_pulse_off", int'(o_hit), 0);
    clear_obs();
    n = 0;
    while (o_dead && n < 100) begin
      strobe();
      n++;
    end
    cmp("hold_frames", n, 30);
    cmp("hold_exit_state", int'(o_state), 0);

    // Abutting on the right edge is not a hit; one pixel in is
    set_obs(0, 331, 350, 449, 471);
    idle(1);
    strobe();
    cmp("abut_state", int'(o_state), 0);
    cmp("abut_lives", int'(o_lives), 2);
    set_obs(0, 330, 350, 449, 471);
    idle(1);
    strobe();
    cmp("edge_hit_state", int'(o_state), 1);
    cmp("edge_hit_lives", int'(o_lives), 1);
    clear_obs();
    strobe_until("edge_hold_exit", 0, 40);

    // Goal row reached with nothing in the way
    set_frog(309, 331, 20, 42);
    idle(1);
    strobe();
    cmp("goal1_pulse", int'(o_goal), 1);
    cmp("goal1_score", int'(o_score), 1);
    cmp("goal1_state", int'(o_state), 2);

    // Keep scoring up to the ceiling, then one more goal
    n = 0;
    while (int'(o_score) < 255 && n < 9000) begin
      strobe();
      n++;
    end
    cmp("score_reach_255", int'(o_score), 255);
    strobe_until("sat_hold_exit", 0, 40);
    strobe();
    cmp("sat_goal_pulse", int'(o_goal), 1);
    cmp("sat_score", int'(o_score), 255);

    // Hit and goal together: hit wins, last life lost, game over
    set_obs(1, 300, 340, 10, 50);
    strobe_until("combo_hold_exit", 0, 40);
    strobe();
    cmp("combo_hit", int'(o_hit), 1);
    cmp("combo_goal", int'(o_goal), 0);
    cmp("combo_score", int'(o_score), 255);
    cmp("combo_lives", int'(o_lives), 0);
    strobe_until("over_state", 3, 40);
    repeat (5) strobe();
    cmp("over_stuck", int'(o_state), 3);
    cmp("over_dead", int'(o_dead), 1);

    // Reset recovers from game over
    @(negedge i_clk) i_rst = 1'b1;
    @(negedge i_clk) i_rst = 1'b0;
    cmp("rst2_state", int'(o_state), 0);
    cmp("rst2_lives", int'(o_lives), 3);
    cmp("rst2_score", int'(o_score), 0);

    // Frozen while not animating even with an overlap present
    clear_obs();
    set_frog(309, 331, 449, 471);
    set_obs(2, 320, 360, 440, 480);
    i_animate = 1'b0;
    idle(1);
    repeat (5) strobe();
    cmp("frozen_state", int'(o_state), 0);
    cmp("frozen_lives", int'(o_lives), 3);
    i_animate = 1'b1;
    strobe();
    cmp("thaw_hit_state", int'(o_state), 1);
    cmp("thaw_hit_lives", int'(o_lives), 2);
    repeat (3) strobe();

    // Reset during the hold wins over a coincident strobe
    clear_obs();
    @(negedge i_clk) begin i_rst = 1'b1; i_ani_stb = 1'b1; end
    @(negedge i_clk) begin i_rst = 1'b0; i_ani_stb = 1'b0; end
    cmp("rst_hold_state", int'(o_state), 0);
    cmp("rst_hold_lives", int'(o_lives), 3);
    cmp("rst_hold_dead",  int'(o_dead),  0);
    idle(3);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
